// File: rtl/fifo_pkg.sv
// +------------------------------------------------------------------+
// | fifo_pkg : shared defaults and helper function for fifo_n        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package fifo_pkg;

  localparam int FIFO_DEFAULT_WIDTH = 32;
  localparam int FIFO_DEFAULT_DEPTH = 4;

  // Ceiling log2, usable in constant expressions for pointer widths.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage : fifo_pkg

`default_nettype wire

// File: rtl/fifo_n_mem.sv
// +------------------------------------------------------------------+
// | fifo_n_mem : DEPTH x WIDTH storage, one write port, async read   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module fifo_n_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_DEFAULT_WIDTH,
  parameter int DEPTH = FIFO_DEFAULT_DEPTH,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  // Storage is intentionally not reset; occupancy tracking makes stale data invisible.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule : fifo_n_mem

`default_nettype wire

// File: rtl/fifo_n.sv
// +------------------------------------------------------------------+
// | fifo_n : N-deep synchronous FIFO with enq/deq/first/clear methods|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module fifo_n
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_DEFAULT_WIDTH,
  parameter int DEPTH = FIFO_DEFAULT_DEPTH
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     enq__ENA,
  input  logic [WIDTH-1:0]         enq_v,
  output logic                     enq__RDY,
  input  logic                     deq__ENA,
  output logic                     deq__RDY,
  input  logic                     clear__ENA,
  output logic                     clear__RDY,
  output logic                     first__RDY,
  output logic [WIDTH-1:0]         first,
  output logic                     notEmpty,
  output logic                     notFull,
  output logic [clog2(DEPTH):0]    count
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] c_full_count = (AW+1)'(DEPTH);

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic          w_enq_fire;
  logic          w_deq_fire;
  logic          w_mem_we;

  // Handshake outputs depend only on registered occupancy, never on an ENA input.
  assign notEmpty   = (count_q != '0);
  assign notFull    = (count_q != c_full_count);
  assign enq__RDY   = notFull;
  assign deq__RDY   = notEmpty;
  assign first__RDY = notEmpty;
  assign clear__RDY = 1'b1;
  assign count      = count_q;

  assign w_enq_fire = enq__ENA & notFull;
  assign w_deq_fire = deq__ENA & notEmpty;
  assign w_mem_we   = w_enq_fire & ~clear__ENA;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear__ENA) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_enq_fire) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (w_deq_fire) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({w_enq_fire, w_deq_fire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  fifo_n_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (CLK),
    .i_we    (w_mem_we),
    .i_waddr (wr_ptr_q),
    .i_wdata (enq_v),
    .i_raddr (rd_ptr_q),
    .o_rdata (first)
  );

endmodule : fifo_n

`default_nettype wire

// File: tb/tb_fifo_n.sv
// +------------------------------------------------------------------+
// | tb_fifo_n : scoreboard bench for fifo_n (WIDTH=8, DEPTH=4)       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_fifo_n;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int AW = 2;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          enq__ENA;
  logic [W-1:0]  enq_v;
  logic          enq__RDY;
  logic          deq__ENA;
  logic          deq__RDY;
  logic          clear__ENA;
  logic          clear__RDY;
  logic          first__RDY;
  logic [W-1:0]  first;
  logic          notEmpty;
  logic          notFull;
  logic [AW:0]   count;

  logic [W-1:0]  exp_q [$];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            mcount  = 0;

  fifo_n #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .enq__ENA   (enq__ENA),
    .enq_v      (enq_v),
    .enq__RDY   (enq__RDY),
    .deq__ENA   (deq__ENA),
    .deq__RDY   (deq__RDY),
    .clear__ENA (clear__ENA),
    .clear__RDY (clear__RDY),
    .first__RDY (first__RDY),
    .first      (first),
    .notEmpty   (notEmpty),
    .notFull    (notFull),
    .count      (count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".count"},      32'(count),      32'(mcount));
    chk({tag, ".notEmpty"},   32'(notEmpty),   32'(mcount != 0));
    chk({tag, ".notFull"},    32'(notFull),    32'(mcount != D));
    chk({tag, ".enq__RDY"},   32'(enq__RDY),   32'(mcount != D));
    chk({tag, ".deq__RDY"},   32'(deq__RDY),   32'(mcount != 0));
    chk({tag, ".first__RDY"}, 32'(first__RDY), 32'(mcount != 0));
    chk({tag, ".clear__RDY"}, 32'(clear__RDY), 32'd1);
  endtask

  // One clock of stimulus; expected data goes to the scoreboard as it is issued.
  task automatic cyc(input string tag, input bit e, input logic [W-1:0] v,
                     input bit d, input bit c);
    bit ef, df;
    ef = e && (mcount != D);
    df = d && (mcount != 0);
    enq__ENA   = e;
    enq_v      = v;
    deq__ENA   = d;
    clear__ENA = c;
    if (c) exp_q.delete();
    else if (ef) exp_q.push_back(v);
    @(posedge CLK);
    #1;
    enq__ENA   = 1'b0;
    deq__ENA   = 1'b0;
    clear__ENA = 1'b0;
    if (c) mcount = 0;
    else   mcount = mcount + int'(ef) - int'(df);
    check_state(tag);
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard whenever a deq fires.
  always @(negedge CLK) begin
    if (nRST === 1'b1) begin
      if (enq__ENA) chk("protocol.enq", 32'(enq__RDY), 32'd1);
      if (deq__ENA) chk("protocol.deq", 32'(deq__RDY), 32'd1);
      if (deq__ENA && deq__RDY) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL deq.underflow: got 0x%0h, expected no data", first);
        end else begin
          chk("deq.first", 32'(first), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nRST       = 1'b0;
    enq__ENA   = 1'b0;
    enq_v      = '0;
    deq__ENA   = 1'b0;
    clear__ENA = 1'b0;

    // 1 Reset
    #22;
    check_state("reset_held");
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    check_state("reset_released");

    // 2 Fill / drain
    for (int i = 0; i < 4; i++) cyc("fill", 1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
    chk("full.count", 32'(count), 32'd4);
    chk("full.enq__RDY", 32'(enq__RDY), 32'd0);
    chk("full.first", 32'(first), 32'hA0);
    for (int i = 0; i < 4; i++) cyc("drain", 1'b0, '0, 1'b1, 1'b0);
    chk("drained.count", 32'(count), 32'd0);

    // 3 Simultaneous enq + deq at count=2
    cyc("simul_pre", 1'b1, 8'hB0, 1'b0, 1'b0);
    cyc("simul_pre", 1'b1, 8'hB1, 1'b0, 1'b0);
    cyc("simul", 1'b1, 8'hC0, 1'b1, 1'b0);
    chk("simul.count", 32'(count), 32'd2);
    chk("simul.first", 32'(first), 32'hB1);
    cyc("simul_drain", 1'b0, '0, 1'b1, 1'b0);
    cyc("simul_drain", 1'b0, '0, 1'b1, 1'b0);

    // 4 Pointer wrap with alternating enq / deq
    for (int i = 0; i < 10; i++) begin
      cyc("wrap_enq", 1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
      chk("wrap.first", 32'(first), 32'h10 + 32'(i));
      cyc("wrap_deq", 1'b0, '0, 1'b1, 1'b0);
    end

    // 5 Clear overrides a same-cycle enq
    for (int i = 0; i < 3; i++) cyc("clear_pre", 1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
    chk("clear_pre.count", 32'(count), 32'd3);
    cyc("clear", 1'b1, 8'hEE, 1'b0, 1'b1);
    chk("clear.count", 32'(count), 32'd0);
    chk("clear.deq__RDY", 32'(deq__RDY), 32'd0);
    cyc("post_clear", 1'b1, 8'hD0, 1'b0, 1'b0);
    chk("post_clear.first", 32'(first), 32'hD0);
    cyc("post_clear_deq", 1'b0, '0, 1'b1, 1'b0);

    // 6 Asynchronous reset between clock edges
    cyc("areset_pre", 1'b1, 8'hE0, 1'b0, 1'b0);
    cyc("areset_pre", 1'b1, 8'hE1, 1'b0, 1'b0);
    #2;
    nRST = 1'b0;
    #1;
    chk("areset.notEmpty", 32'(notEmpty), 32'd0);
    chk("areset.count", 32'(count), 32'd0);
    chk("areset.enq__RDY", 32'(enq__RDY), 32'd1);
    exp_q.delete();
    mcount = 0;
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    check_state("areset_released");
    cyc("areset_post", 1'b1, 8'hF0, 1'b0, 1'b0);
    cyc("areset_post_deq", 1'b0, '0, 1'b1, 1'b0);

    chk("scoreboard.empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_fifo_n

`default_nettype wire
